// File: rtl/arm_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_pipe_pkg
// Description : Shared memory-stage types and constants for the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_pipe_pkg;

    typedef logic [1:0] mem_ctrl_state_t;

    localparam mem_ctrl_state_t c_ST_IDLE = 2'd0;
    localparam mem_ctrl_state_t c_ST_LO   = 2'd1;
    localparam mem_ctrl_state_t c_ST_HI   = 2'd2;
    localparam mem_ctrl_state_t c_ST_DONE = 2'd3;

    localparam logic [31:0] c_DEFAULT_BASE_ADDR = 32'd1024;

endpackage
`default_nettype wire

// File: rtl/mem_addr_map.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_map
// Description : CPU byte address to SRAM 32-bit word index (base-relative).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_map #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int          SRAM_AW   = 18
) (
    input  wire logic [31:0]        address,
    output      logic [SRAM_AW-2:0] word
);

    logic [31:0] w_diff;
    logic        w_unused_bits;

    assign w_diff        = address - BASE_ADDR;
    // Out-of-range addresses wrap silently; only the low word bits matter.
    assign word          = w_diff[SRAM_AW:2];
    assign w_unused_bits = ^{w_diff[31:SRAM_AW+1], w_diff[1:0]};

endmodule
`default_nettype wire

// File: rtl/mem_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_controller
// Description : Splits 32-bit loads/stores into two timed 16-bit async SRAM
//               accesses and freezes the pipeline until done.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_controller
    import arm_pipe_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = c_DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               rd_en,
    input  wire logic               wr_en,
    input  wire logic [31:0]        address,
    input  wire logic [31:0]        write_data,
    output      logic [31:0]        read_data,
    output      logic               ready,
    output      logic [SRAM_AW-1:0] sram_addr,
    output      logic               sram_we_n,
    output      logic [15:0]        sram_dq_out,
    output      logic               sram_dq_oe,
    input  wire logic [15:0]        sram_dq_in
);

    localparam int               c_CNT_W   = $clog2(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WAIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_WE_LAST = c_CNT_W'(WAIT_CYCLES - 3);

    mem_ctrl_state_t      r_state,     w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic                 r_is_wr,     w_is_wr_nxt;
    logic [SRAM_AW-2:0]   r_word,      w_word_nxt;
    logic [31:0]          r_wdata,     w_wdata_nxt;
    logic [31:0]          r_read_data, w_read_data_nxt;
    logic [SRAM_AW-1:0]   r_sram_addr, w_sram_addr_nxt;
    logic                 r_we_n,      w_we_n_nxt;
    logic [15:0]          r_dq_out,    w_dq_out_nxt;
    logic                 r_dq_oe,     w_dq_oe_nxt;
    logic [SRAM_AW-2:0]   w_req_word;
    logic                 w_req;

    mem_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .address (address),
        .word    (w_req_word)
    );

    assign w_req = rd_en | wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_word      <= w_word_nxt;
            r_wdata     <= w_wdata_nxt;
            r_read_data <= w_read_data_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_we_n      <= w_we_n_nxt;
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_is_wr_nxt     = r_is_wr;
        w_word_nxt      = r_word;
        w_wdata_nxt     = r_wdata;
        w_read_data_nxt = r_read_data;
        w_sram_addr_nxt = r_sram_addr;
        w_we_n_nxt      = 1'b1;
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = r_dq_oe;
        ready           = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                ready = ~w_req;
                if (w_req) begin
                    // A simultaneous read+write request is resolved as a write.
                    w_state_nxt     = c_ST_LO;
                    w_cnt_nxt       = '0;
                    w_is_wr_nxt     = wr_en;
                    w_word_nxt      = w_req_word;
                    w_wdata_nxt     = write_data;
                    w_sram_addr_nxt = {w_req_word, 1'b0};
                    w_dq_out_nxt    = write_data[15:0];
                    w_dq_oe_nxt     = wr_en;
                end
            end

            c_ST_LO, c_ST_HI: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_state == c_ST_LO) begin
                        w_state_nxt     = c_ST_HI;
                        w_sram_addr_nxt = {r_word, 1'b1};
                        w_dq_out_nxt    = r_wdata[31:16];
                        if (!r_is_wr) begin
                            w_read_data_nxt[15:0] = sram_dq_in;
                        end
                    end else begin
                        w_state_nxt = c_ST_DONE;
                        w_dq_oe_nxt = 1'b0;
                        if (!r_is_wr) begin
                            w_read_data_nxt[31:16] = sram_dq_in;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    // Strobe covers counts 1..WAIT_CYCLES-2: one cycle of setup and hold.
                    w_we_n_nxt = ~(r_is_wr && (r_cnt <= c_WE_LAST));
                end
            end

            c_ST_DONE: begin
                ready       = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_we_n   = r_we_n;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sram_controller
// Description : Directed self-checking bench for mem_sram_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sram_controller;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    logic [15:0] mem [0:15];

    int n_tests;
    int n_fail;

    mem_sram_controller #(
        .WAIT_CYCLES (5),
        .BASE_ADDR   (32'd1024),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM model: combinational read, write latched while we_n low.
    assign sram_dq_in = mem[sram_addr[3:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end

    // Launches one request (called at posedge+1) and runs to the ready cycle.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int freeze,
                             output int we_lo, output int oe_on, output logic [31:0] rdat,
                             output bit timeout);
        rd_en      = rd;
        wr_en      = wr;
        address    = addr;
        write_data = data;
        freeze  = 0;
        we_lo   = 0;
        oe_on   = 0;
        rdat    = '0;
        timeout = 1'b1;
        #1;
        if (!ready) freeze++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            rd_en = 1'b0;
            wr_en = 1'b0;
            #1;
            if (!sram_we_n) we_lo++;
            if (sram_dq_oe) oe_on++;
            if (ready) begin
                rdat    = read_data;
                timeout = 1'b0;
                break;
            end
            freeze++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b we_n=%b oe=%b, required 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
        n_tests++;
        if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: read_data=%h addr=%h dq_out=%h, required 0 0 0", read_data, sram_addr, sram_dq_out);
        end
        next_cycle();
        n_tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: ready=%b we_n=%b oe=%b, required 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
    endtask

    task automatic test_store();
        int freeze = 0;
        int we_lo_a = 0;
        int we_lo_b = 0;
        bit done = 0;
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'd1028;
        write_data = 32'hDEADBEEF;
        #1;
        if (!ready) freeze++;
        for (int cyc = 1; cyc < 40 && !done; cyc++) begin
            next_cycle();
            wr_en = 1'b0;
            if (cyc == 1) begin
                n_tests++;
                if (sram_addr !== 18'd2 || sram_dq_out !== 16'hBEEF || sram_dq_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL store_lo: addr=%0d dq=%h oe=%b, required 2 beef 1", sram_addr, sram_dq_out, sram_dq_oe);
                end
            end
            if (cyc == 6) begin
                n_tests++;
                if (sram_addr !== 18'd3 || sram_dq_out !== 16'hDEAD || sram_dq_oe !== 1'b1) begin
                    n_fail++;
                    $display("FAIL store_hi: addr=%0d dq=%h oe=%b, required 3 dead 1", sram_addr, sram_dq_out, sram_dq_oe);
                end
            end
            if (!sram_we_n && sram_addr == 18'd2) we_lo_a++;
            if (!sram_we_n && sram_addr == 18'd3) we_lo_b++;
            if (ready) done = 1;
            else freeze++;
        end
        n_tests++;
        if (freeze !== 11) begin
            n_fail++;
            $display("FAIL store_freeze: %0d cycles, required 11", freeze);
        end
        n_tests++;
        if (we_lo_a !== 3 || we_lo_b !== 3) begin
            n_fail++;
            $display("FAIL store_we_width: lo=%0d hi=%0d, required 3 3", we_lo_a, we_lo_b);
        end
        n_tests++;
        if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
            n_fail++;
            $display("FAIL store_mem: w2=%h w3=%h, required beef dead", mem[2], mem[3]);
        end
        next_cycle();
        n_tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL store_idle: ready=%b we_n=%b oe=%b, required 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
    endtask

    task automatic test_load();
        int freeze, we_lo, oe_on;
        logic [31:0] rdat;
        bit to;
        do_access(1'b1, 1'b0, 32'd1028, 32'h0, freeze, we_lo, oe_on, rdat, to);
        n_tests++;
        if (to || rdat !== 32'hDEADBEEF || freeze !== 11) begin
            n_fail++;
            $display("FAIL load_data: data=%h freeze=%0d timeout=%b, required deadbeef 11 0", rdat, freeze, to);
        end
        n_tests++;
        if (we_lo !== 0 || oe_on !== 0) begin
            n_fail++;
            $display("FAIL load_bus: we_low=%0d oe_on=%0d, required 0 0", we_lo, oe_on);
        end
        next_cycle();
        n_tests++;
        if (ready !== 1'b1 || read_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL load_hold: ready=%b data=%h, required 1 deadbeef", ready, read_data);
        end
    endtask

    task automatic test_both_high();
        int freeze, we_lo, oe_on;
        logic [31:0] rdat;
        bit to;
        do_access(1'b1, 1'b1, 32'd1024, 32'h00010002, freeze, we_lo, oe_on, rdat, to);
        n_tests++;
        if (to || freeze !== 11 || we_lo !== 6) begin
            n_fail++;
            $display("FAIL both_timing: freeze=%0d we_low=%0d timeout=%b, required 11 6 0", freeze, we_lo, to);
        end
        n_tests++;
        if (mem[0] !== 16'h0002 || mem[1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL both_mem: w0=%h w1=%h, required 0002 0001", mem[0], mem[1]);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [23:0] trace;
        logic [31:0] first_data;
        trace      = '0;
        first_data = '0;
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        address = 32'd1028;
        #1;
        trace[0] = ready;
        for (int cyc = 1; cyc < 24; cyc++) begin
            next_cycle();
            trace[cyc] = ready;
            if (cyc == 11) begin
                first_data = read_data;
                address    = 32'd1024;
            end
        end
        n_tests++;
        if (trace !== 24'h800800) begin
            n_fail++;
            $display("FAIL b2b_ready_trace: %b, required %b", trace, 24'h800800);
        end
        n_tests++;
        if (first_data !== 32'hDEADBEEF || read_data !== 32'h00010002) begin
            n_fail++;
            $display("FAIL b2b_data: first=%h second=%h, required deadbeef 00010002", first_data, read_data);
        end
        rd_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_write();
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'd1032;
        write_data = 32'h12345678;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            next_cycle();
            wr_en = 1'b0;
        end
        n_tests++;
        if (sram_we_n !== 1'b0 || sram_addr !== 18'd5) begin
            n_fail++;
            $display("FAIL mid_pre: we_n=%b addr=%0d, required 0 5", sram_we_n, sram_addr);
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b we_n=%b oe=%b, required 1 1 0", ready, sram_we_n, sram_dq_oe);
        end
        next_cycle();
        n_tests++;
        if (ready !== 1'b1 || mem[4] !== 16'h5678) begin
            n_fail++;
            $display("FAIL mid_after: ready=%b w4=%h, required 1 5678", ready, mem[4]);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = '0;
        write_data = '0;
        test_reset();
        test_store();
        test_load();
        test_both_high();
        test_back_to_back();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
